// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Scoreboard-based issue controller for the ID stage of a 5-stage pipeline.
// It tracks which architectural registers have a write in flight and holds
// the front end on RAW, WAW or mul/div-busy hazards. It also sequences the
// single multi-cycle mul/div unit and keeps a saturating stall counter for
// debug.
//
// Handshake: id_valid is the ID stage's "valid", and issue is the
// controller's "ready & valid". An instruction is consumed exactly on a
// cycle with issue=1. While stall=1 the instruction is held in IF/ID and
// must remain stable, and a NOP is injected into ID/EX (bubble=1).
//
// Ports
//   clk, rst        pipeline clock, asynchronous active-high reset
//   id_valid        valid instruction in ID
//   id_rs / id_rt   source register indices, qualified by id_uses_rs/rt
//   id_rd           destination index, qualified by id_writes_reg
//   id_is_muldiv    instruction needs the mul/div unit
//   wb_valid/wb_reg register file write this cycle
//   md_done         one-cycle completion pulse from the mul/div unit
//   stall, bubble   hold PC and IF/ID, force NOP into ID/EX
//   issue           ID instruction advances this cycle
//   md_start        one-cycle start pulse to the mul/div unit
//   md_busy         mul/div FSM state (1 = BUSY); also the FSM debug view
//   pending         scoreboard bit vector, one bit per register
//   stall_count     saturating count of stalled cycles
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int CW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [AW-1:0]    id_rd,
  input  logic             id_writes_reg,
  input  logic             id_is_muldiv,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_reg,
  input  logic             md_done,
  output logic             stall,
  output logic             bubble,
  output logic             issue,
  output logic             md_start,
  output logic             md_busy,
  output logic [NREGS-1:0] pending,
  output logic [CW-1:0]    stall_count
);

  localparam logic [0:0] MD_IDLE = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

  logic [0:0]       md_state;
  logic [0:0]       md_state_nxt;
  logic [NREGS-1:0] eff_pending;
  logic [NREGS-1:0] pending_nxt;
  logic             raw;
  logic             waw;
  logic             mdh;
  logic             hazard;
  logic             rd_nonzero;

  // A register being written back this cycle is already readable: the
  // register file writes in the first half-cycle, so its bit is masked
  // before hazard evaluation.
  always_comb begin
    eff_pending = pending;
    if (wb_valid) begin
      eff_pending[wb_reg] = 1'b0;
    end
  end

  assign rd_nonzero = (id_rd != '0);

  assign raw = (id_uses_rs & eff_pending[id_rs]) |
               (id_uses_rt & eff_pending[id_rt]);
  assign waw = id_writes_reg & rd_nonzero & eff_pending[id_rd];
  // A completing operation frees the unit in the same cycle, so a waiting
  // mul/div can start back-to-back.
  assign mdh = id_is_muldiv & md_busy & ~md_done;

  assign hazard = id_valid & (raw | waw | mdh);

  // Outputs are forced inactive while reset is held; everything is a pure
  // function of registered state and current inputs (no loop through issue).
  assign stall    = ~rst & hazard;
  assign bubble   = stall;
  assign issue    = ~rst & id_valid & ~hazard;
  assign md_start = issue & id_is_muldiv;

  // Scoreboard next state: clear on writeback first, then set for the
  // issuing writer, so a set wins over a clear on the same index.
  always_comb begin
    pending_nxt = pending;
    if (wb_valid) begin
      pending_nxt[wb_reg] = 1'b0;
    end
    if (issue && id_writes_reg && rd_nonzero) begin
      pending_nxt[id_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Mul/div unit sequencer. md_done while IDLE is a stray pulse and ignored.
  always_comb begin
    md_state_nxt = md_state;
    case (md_state)
      MD_IDLE: begin
        if (md_start) begin
          md_state_nxt = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (md_done && !md_start) begin
          md_state_nxt = MD_IDLE;
        end
      end
      default: md_state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_state <= MD_IDLE;
    end else begin
      md_state <= md_state_nxt;
    end
  end

  assign md_busy = (md_state == MD_BUSY);

  // Debug stall counter, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CW{1'b1}})) begin
      stall_count <= stall_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int CW    = 32;
  localparam int W     = 5 + NREGS + CW;

  logic             clk;
  logic             rst;
  logic             id_valid;
  logic [AW-1:0]    id_rs;
  logic [AW-1:0]    id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [AW-1:0]    id_rd;
  logic             id_writes_reg;
  logic             id_is_muldiv;
  logic             wb_valid;
  logic [AW-1:0]    wb_reg;
  logic             md_done;
  logic             stall;
  logic             bubble;
  logic             issue;
  logic             md_start;
  logic             md_busy;
  logic [NREGS-1:0] pending;
  logic [CW-1:0]    stall_count;

  pipeline_hazard_ctrl #(.NREGS(NREGS), .AW(AW), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_rd        (id_rd),
    .id_writes_reg(id_writes_reg),
    .id_is_muldiv (id_is_muldiv),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .md_done      (md_done),
    .stall        (stall),
    .bubble       (bubble),
    .issue        (issue),
    .md_start     (md_start),
    .md_busy      (md_busy),
    .pending      (pending),
    .stall_count  (stall_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           tag_q[$];
  int           vec_no  = 0;
  int           n_checks = 0;
  int           n_errors = 0;
  bit           drv_done = 1'b0;

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the falling edge; the monitor samples
  // 3 units after it, well before the next rising edge.
  task automatic tick();
    @(negedge clk);
    #1;
    id_valid      = 1'b0;
    id_rs         = '0;
    id_rt         = '0;
    id_uses_rs    = 1'b0;
    id_uses_rt    = 1'b0;
    id_rd         = '0;
    id_writes_reg = 1'b0;
    id_is_muldiv  = 1'b0;
    wb_valid      = 1'b0;
    wb_reg        = '0;
    md_done       = 1'b0;
  endtask

  task automatic set_id(input logic [AW-1:0] rs, input logic urs,
                        input logic [AW-1:0] rt, input logic urt,
                        input logic [AW-1:0] rd, input logic wr,
                        input logic md);
    id_valid      = 1'b1;
    id_rs         = rs;
    id_uses_rs    = urs;
    id_rt         = rt;
    id_uses_rt    = urt;
    id_rd         = rd;
    id_writes_reg = wr;
    id_is_muldiv  = md;
  endtask

  task automatic set_wb(input logic [AW-1:0] r);
    wb_valid = 1'b1;
    wb_reg   = r;
  endtask

  // Expected: stall (bubble equals stall), issue, md_start, md_busy,
  // pending vector as it stands before the next edge, stall_count likewise.
  task automatic expect_out(input logic st, input logic is, input logic ms,
                            input logic mb, input logic [NREGS-1:0] pend,
                            input logic [CW-1:0] cnt);
    exp_q.push_back({st, st, is, ms, mb, pend, cnt});
    tag_q.push_back(vec_no);
    vec_no++;
  endtask

  function automatic logic [NREGS-1:0] p(input int n);
    logic [NREGS-1:0] one;
    one = 1;
    return one << n;
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [W-1:0] act;
    logic [W-1:0] exp_v;
    int           tag;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        tag   = tag_q.pop_front();
        act   = {stall, bubble, issue, md_start, md_busy, pending, stall_count};
        n_checks++;
        if (act !== exp_v) begin
          n_errors++;
          $display("FAIL vec%0d outputs: actual st/bb/is/ms/mb=%b pend=%h cnt=%0d required st/bb/is/ms/mb=%b pend=%h cnt=%0d",
                   tag, act[W-1 -: 5], act[CW +: NREGS], act[CW-1:0],
                   exp_v[W-1 -: 5], exp_v[CW +: NREGS], exp_v[CW-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : driver
    rst           = 1'b1;
    id_valid      = 1'b0;
    id_rs         = '0;
    id_rt         = '0;
    id_uses_rs    = 1'b0;
    id_uses_rt    = 1'b0;
    id_rd         = '0;
    id_writes_reg = 1'b0;
    id_is_muldiv  = 1'b0;
    wb_valid      = 1'b0;
    wb_reg        = '0;
    md_done       = 1'b0;

    // Reset held three cycles; a valid instruction during reset must not issue.
    tick(); expect_out(0, 0, 0, 0, '0, 0);
    tick(); set_id(3, 1, 0, 0, 4, 1, 1); expect_out(0, 0, 0, 0, '0, 0);
    tick(); expect_out(0, 0, 0, 0, '0, 0);
    tick(); rst = 1'b0; expect_out(0, 0, 0, 0, '0, 0);

    // RAW on rs=15: three stalled cycles, issue in the writeback cycle.
    tick(); set_id(0, 0, 0, 0, 15, 1, 0); expect_out(0, 1, 0, 0, '0, 0);
    tick(); set_id(15, 1, 0, 0, 0, 0, 0); expect_out(1, 0, 0, 0, p(15), 0);
    tick(); set_id(15, 1, 0, 0, 0, 0, 0); expect_out(1, 0, 0, 0, p(15), 1);
    tick(); set_id(15, 1, 0, 0, 0, 0, 0); expect_out(1, 0, 0, 0, p(15), 2);
    tick(); set_id(15, 1, 0, 0, 0, 0, 0); set_wb(15);
    expect_out(0, 1, 0, 0, p(15), 3);
    tick(); expect_out(0, 0, 0, 0, '0, 3);

    // Register zero never becomes pending.
    tick(); set_id(0, 0, 0, 0, 0, 1, 0); expect_out(0, 1, 0, 0, '0, 3);
    tick(); set_id(0, 1, 0, 1, 0, 0, 0); expect_out(0, 1, 0, 0, '0, 3);

    // WAW on rd=8, then writeback and new writer of 8 in the same cycle.
    tick(); set_id(0, 0, 0, 0, 8, 1, 0); expect_out(0, 1, 0, 0, '0, 3);
    tick(); set_id(0, 0, 0, 0, 8, 1, 0); expect_out(1, 0, 0, 0, p(8), 3);
    tick(); set_id(0, 0, 0, 0, 8, 1, 0); set_wb(8);
    expect_out(0, 1, 0, 0, p(8), 4);
    tick(); expect_out(0, 0, 0, 0, p(8), 4);
    tick(); set_wb(8); expect_out(0, 0, 0, 0, p(8), 4);
    // Writeback of a register that is not pending is harmless.
    tick(); set_wb(20); expect_out(0, 0, 0, 0, '0, 4);
    tick(); expect_out(0, 0, 0, 0, '0, 4);

    // Mul/div: start, second op waits, back-to-back start on md_done.
    tick(); set_id(0, 0, 0, 0, 10, 1, 1); expect_out(0, 1, 1, 0, '0, 4);
    tick(); set_id(0, 0, 0, 0, 11, 1, 1); expect_out(1, 0, 0, 1, p(10), 4);
    tick(); set_id(0, 0, 0, 0, 11, 1, 1); expect_out(1, 0, 0, 1, p(10), 5);
    tick(); set_id(0, 0, 0, 0, 11, 1, 1); md_done = 1'b1;
    expect_out(0, 1, 1, 1, p(10), 6);
    tick(); expect_out(0, 0, 0, 1, p(10) | p(11), 6);
    tick(); set_wb(10); expect_out(0, 0, 0, 1, p(10) | p(11), 6);
    tick(); set_wb(11); md_done = 1'b1; expect_out(0, 0, 0, 1, p(11), 6);
    tick(); expect_out(0, 0, 0, 0, '0, 6);
    // Stray md_done while idle is ignored.
    tick(); md_done = 1'b1; expect_out(0, 0, 0, 0, '0, 6);
    tick(); expect_out(0, 0, 0, 0, '0, 6);

    // RAW through rt only; rt match is ignored when id_uses_rt=0.
    tick(); set_id(0, 0, 0, 0, 5, 1, 0); expect_out(0, 1, 0, 0, '0, 6);
    tick(); set_id(5, 0, 5, 1, 0, 0, 0); expect_out(1, 0, 0, 0, p(5), 6);
    tick(); set_id(5, 0, 5, 0, 0, 0, 0); expect_out(0, 1, 0, 0, p(5), 7);
    tick(); set_wb(5); expect_out(0, 0, 0, 0, p(5), 7);
    tick(); expect_out(0, 0, 0, 0, '0, 7);

    // Reset asserted mid-stall, checked before any further rising edge.
    tick(); set_id(0, 0, 0, 0, 17, 1, 0); expect_out(0, 1, 0, 0, '0, 7);
    tick(); set_id(17, 1, 0, 0, 0, 0, 0); expect_out(1, 0, 0, 0, p(17), 7);
    tick(); set_id(17, 1, 0, 0, 0, 0, 0); rst = 1'b1;
    expect_out(0, 0, 0, 0, '0, 0);
    tick(); rst = 1'b0; expect_out(0, 0, 0, 0, '0, 0);

    tick();
    tick();
    drv_done = 1'b1;
  end

  // ---------------- final report ----------------
  initial begin : report
    int guard;
    guard = 0;
    while (!drv_done && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    if (!drv_done) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: actual driver still running, required done within 2000 cycles");
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: actual %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
